// File: rtl/mem_stage.sv
// mem_stage: load/store and writeback stage behind execute.
// Non-memory ops write back one cycle after acceptance. Loads and stores run
// a single req/ack bus transaction (IDLE -> ACCESS -> RESP) while stall holds
// upstream. An optional ack timeout aborts the access with a bus_err pulse.
// Optional feature macro: MEM_STAGE_MISALIGN_TRAP_EN. When it is defined,
// misaligned h/w accesses are rejected with bus_err instead of reaching the bus.
module mem_stage #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  func3,
    input  logic [31:0] result,
    input  logic [31:0] store_data,
    input  logic [4:0]  dest_i,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        wb_valid,
    output logic [4:0]  wb_dest,
    output logic [31:0] wb_data,
    output logic        bus_err
);

    localparam int unsigned CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (ACK_TIMEOUT > 0) ? CNT_W'(ACK_TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] ack_cnt;

    // Op context captured at acceptance and bus data captured at ack
    logic             load_p1;
    logic [2:0]       f3_p1;
    logic [1:0]       lane_p1;
    logic [4:0]       dest_p1;
    logic [31:0]      rdata_p2;

    logic             accept;
    logic             is_mem;
    logic             size_b;
    logic             size_h;
    logic             trap;
    logic             ack_hit;
    logic             timeout_hit;

    // Replicate store data across every lane the access size can hit
    function automatic logic [31:0] store_lanes(input logic [31:0] sd, input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return {4{sd[7:0]}};
            3'b001, 3'b101: return {2{sd[15:0]}};
            default:        return sd;
        endcase
    endfunction

    // Byte enables for a store of the given size at the given byte offset
    function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] ofs);
        case (f3)
            3'b000, 3'b100: return 4'b0001 << ofs;
            3'b001, 3'b101: return ofs[1] ? 4'b1100 : 4'b0011;
            default:        return 4'b1111;
        endcase
    endfunction

    // Pick the addressed byte/half out of the read word and extend it
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] f3,
                                                 input logic [1:0] ofs);
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        logic signed [31:0] ext_s;
        byte_s = word[{ofs, 3'b000} +: 8];
        half_s = ofs[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000: begin
                ext_s = byte_s;
                return ext_s;
            end
            3'b001: begin
                ext_s = half_s;
                return ext_s;
            end
            3'b100:  return {24'h0, byte_s};
            3'b101:  return {16'h0, half_s};
            default: return word;
        endcase
    endfunction

    assign accept      = in_valid && (state == IDLE);
    assign is_mem      = is_load || is_store;
    assign size_b      = (func3 == 3'b000) || (func3 == 3'b100);
    assign size_h      = (func3 == 3'b001) || (func3 == 3'b101);
    assign ack_hit     = (state == ACCESS) && mem_ack;
    assign timeout_hit = (ACK_TIMEOUT != 0) && (state == ACCESS) && !mem_ack &&
                         (ack_cnt == CNT_LAST);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = (size_h && result[0]) ||
                        (!size_b && !size_h && (result[1:0] != 2'b00));
    assign trap       = accept && is_mem && misaligned;
`else
    assign trap       = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: ack wins over timeout in the same cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && is_mem && !trap) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (ack_hit) begin
                    state_nxt = RESP;
                end else if (timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: upstream is frozen whenever an access is in flight
    always_comb begin
        stall = (state != IDLE);
    end

    // Ack wait counter, zero on the first ACCESS cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_cnt <= '0;
        end else if (state != ACCESS) begin
            ack_cnt <= '0;
        end else begin
            ack_cnt <= ack_cnt + CNT_W'(1);
        end
    end

    // Bus outputs, captured op context and writeback registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_wstrb <= 4'h0;
            wb_valid  <= 1'b0;
            wb_dest   <= 5'h0;
            wb_data   <= 32'h0;
            bus_err   <= 1'b0;
            load_p1   <= 1'b0;
            f3_p1     <= 3'h0;
            lane_p1   <= 2'h0;
            dest_p1   <= 5'h0;
            rdata_p2  <= 32'h0;
        end else begin
            wb_valid <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_mem && trap) begin
                            bus_err <= 1'b1;
                        end else if (is_mem) begin
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {result[31:2], 2'b00};
                            mem_wdata <= store_lanes(store_data, func3);
                            mem_wstrb <= is_store ? store_strobe(func3, result[1:0]) : 4'h0;
                            load_p1   <= !is_store;
                            f3_p1     <= func3;
                            lane_p1   <= result[1:0];
                            dest_p1   <= dest_i;
                        end else begin
                            wb_valid <= (dest_i != 5'd0);
                            wb_dest  <= dest_i;
                            wb_data  <= result;
                        end
                    end
                end
                ACCESS: begin
                    if (ack_hit) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= 4'h0;
                        rdata_p2  <= mem_rdata;
                    end else if (timeout_hit) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= 4'h0;
                        bus_err   <= 1'b1;
                    end
                end
                RESP: begin
                    if (load_p1) begin
                        wb_valid <= (dest_p1 != 5'd0);
                        wb_dest  <= dest_p1;
                        wb_data  <= load_extract(rdata_p2, f3_p1, lane_p1);
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed table-driven bench for mem_stage (ACK_TIMEOUT=4).
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        is_load;
    logic        is_store;
    logic [2:0]  func3;
    logic [31:0] result;
    logic [31:0] store_data;
    logic [4:0]  dest_i;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        wb_valid;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic        bus_err;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    mem_stage #(.ACK_TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .is_load    (is_load),
        .is_store   (is_store),
        .func3      (func3),
        .result     (result),
        .store_data (store_data),
        .dest_i     (dest_i),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .wb_valid   (wb_valid),
        .wb_dest    (wb_dest),
        .wb_data    (wb_data),
        .bus_err    (bus_err)
    );

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [4:0]  dest;
        logic [31:0] rdata;
        int          dly;
        logic        e_wbv;
        logic [31:0] e_wbd;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_wstrb;
        logic        e_we;
    } vec_t;

    localparam int NV = 14;
    vec_t vt [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " stall"},     32'(stall),     32'h0);
        check({tag, " mem_req"},   32'(mem_req),   32'h0);
        check({tag, " mem_we"},    32'(mem_we),    32'h0);
        check({tag, " mem_addr"},  mem_addr,       32'h0);
        check({tag, " mem_wdata"}, mem_wdata,      32'h0);
        check({tag, " mem_wstrb"}, 32'(mem_wstrb), 32'h0);
        check({tag, " wb_valid"},  32'(wb_valid),  32'h0);
        check({tag, " wb_dest"},   32'(wb_dest),   32'h0);
        check({tag, " wb_data"},   wb_data,        32'h0);
        check({tag, " bus_err"},   32'(bus_err),   32'h0);
    endtask

    task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] dest);
        in_valid   = 1'b1;
        is_load    = ld;
        is_store   = st;
        func3      = f3;
        result     = addr;
        store_data = sd;
        dest_i     = dest;
    endtask

    initial begin
        //            ld    st    f3      addr          sd            dest   rdata         dly wbv   wbd           e_addr        e_wdata       wstrb    we
        vt[0]  = '{1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0,        5'd5,  32'h0,        0, 1'b1, 32'h0000_1234, 32'h0,        32'h0,        4'h0,    1'b0};
        vt[1]  = '{1'b0, 1'b0, 3'b000, 32'h0000_DEAD, 32'h0,        5'd0,  32'h0,        0, 1'b0, 32'h0,        32'h0,        32'h0,        4'h0,    1'b0};
        vt[2]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        5'd7,  32'h80FF_FFFF, 3, 1'b1, 32'hFFFF_FF80, 32'h0000_0100, 32'h0,        4'b0000, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0202, 32'h0,        5'd3,  32'hBEEF_1234, 0, 1'b1, 32'h0000_BEEF, 32'h0000_0200, 32'h0,        4'b0000, 1'b0};
        vt[4]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0301, 32'h0000_00AB, 5'd4, 32'h0,        1, 1'b0, 32'h0,        32'h0000_0300, 32'hABAB_ABAB, 4'b0010, 1'b1};
        vt[5]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0404, 32'h0,        5'd9,  32'h1234_5678, 2, 1'b1, 32'h1234_5678, 32'h0000_0404, 32'h0,        4'b0000, 1'b0};
        vt[6]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0502, 32'h0,        5'd10, 32'h8001_7FFF, 0, 1'b1, 32'hFFFF_8001, 32'h0000_0500, 32'h0,        4'b0000, 1'b0};
        vt[7]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0600, 32'h0,        5'd11, 32'h0000_00F0, 1, 1'b1, 32'h0000_00F0, 32'h0000_0600, 32'h0,        4'b0000, 1'b0};
        vt[8]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0702, 32'h1234_ABCD, 5'd1, 32'h0,        0, 1'b0, 32'h0,        32'h0000_0700, 32'hABCD_ABCD, 4'b1100, 1'b1};
        vt[9]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0800, 32'hCAFE_F00D, 5'd2, 32'h0,        2, 1'b0, 32'h0,        32'h0000_0800, 32'hCAFE_F00D, 4'b1111, 1'b1};
        vt[10] = '{1'b1, 1'b0, 3'b010, 32'h0000_0900, 32'h0,        5'd0,  32'h0000_0055, 1, 1'b0, 32'h0,        32'h0000_0900, 32'h0,        4'b0000, 1'b0};
        vt[11] = '{1'b1, 1'b0, 3'b111, 32'h0000_0A00, 32'h0,        5'd12, 32'h8765_4321, 0, 1'b1, 32'h8765_4321, 32'h0000_0A00, 32'h0,        4'b0000, 1'b0};
        vt[12] = '{1'b1, 1'b1, 3'b000, 32'h0000_0B03, 32'h0000_005A, 5'd6, 32'h0,        1, 1'b0, 32'h0,        32'h0000_0B00, 32'h5A5A_5A5A, 4'b1000, 1'b1};
        vt[13] = '{1'b1, 1'b0, 3'b010, 32'h0000_0C06, 32'h0,        5'd14, 32'h1122_3344, 0, 1'b1, 32'h1122_3344, 32'h0000_0C04, 32'h0,        4'b0000, 1'b0};

        reset      = 1'b1;
        in_valid   = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        func3      = 3'b000;
        result     = 32'h0;
        store_data = 32'h0;
        dest_i     = 5'd0;
        mem_rdata  = 32'h0;
        mem_ack    = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        // Idle with no op and a stray ack: nothing happens
        mem_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("idle%0d mem_req", c),  32'(mem_req),  32'h0);
            check($sformatf("idle%0d wb_valid", c), 32'(wb_valid), 32'h0);
            check($sformatf("idle%0d stall", c),    32'(stall),    32'h0);
        end
        mem_ack = 1'b0;

        // Table-driven transactions
        for (int i = 0; i < NV; i++) begin
            int stall_cnt;
            @(negedge clk);
            drive_op(vt[i].ld, vt[i].st, vt[i].f3, vt[i].addr, vt[i].sd, vt[i].dest);
            @(negedge clk);
            in_valid = 1'b0;
            if (!(vt[i].ld || vt[i].st)) begin
                check($sformatf("v%0d wb_valid", i), 32'(wb_valid), 32'(vt[i].e_wbv));
                check($sformatf("v%0d stall", i),    32'(stall),    32'h0);
                if (vt[i].e_wbv) begin
                    check($sformatf("v%0d wb_data", i), wb_data,       vt[i].e_wbd);
                    check($sformatf("v%0d wb_dest", i), 32'(wb_dest),  32'(vt[i].dest));
                end
            end else begin
                check($sformatf("v%0d mem_req", i),   32'(mem_req),   32'h1);
                check($sformatf("v%0d stall", i),     32'(stall),     32'h1);
                check($sformatf("v%0d mem_we", i),    32'(mem_we),    32'(vt[i].e_we));
                check($sformatf("v%0d mem_addr", i),  mem_addr,       vt[i].e_addr);
                check($sformatf("v%0d mem_wstrb", i), 32'(mem_wstrb), 32'(vt[i].e_wstrb));
                check($sformatf("v%0d mem_wdata", i), mem_wdata,      vt[i].e_wdata);
                stall_cnt = 1;
                for (int w = 0; w < vt[i].dly; w++) begin
                    @(negedge clk);
                    if (stall) stall_cnt++;
                end
                mem_rdata = vt[i].rdata;
                mem_ack   = 1'b1;
                @(negedge clk);
                mem_ack   = 1'b0;
                mem_rdata = 32'hDEAD_BEEF;
                if (stall) stall_cnt++;
                check($sformatf("v%0d req_drop", i), 32'(mem_req),  32'h0);
                check($sformatf("v%0d early_wb", i), 32'(wb_valid), 32'h0);
                @(negedge clk);
                check($sformatf("v%0d wb_valid", i),  32'(wb_valid), 32'(vt[i].e_wbv));
                check($sformatf("v%0d stall_rel", i), 32'(stall),    32'h0);
                if (vt[i].e_wbv) begin
                    check($sformatf("v%0d wb_data", i), wb_data,      vt[i].e_wbd);
                    check($sformatf("v%0d wb_dest", i), 32'(wb_dest), 32'(vt[i].dest));
                end
                check($sformatf("v%0d stall_cycles", i), 32'(stall_cnt), 32'(vt[i].dly + 2));
            end
        end

        // Timeout: load with no ack
        begin
            int req_cnt;
            @(negedge clk);
            drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0D00, 32'h0, 5'd13);
            @(negedge clk);
            in_valid = 1'b0;
            req_cnt  = 0;
            for (int c = 0; c < 20; c++) begin
                if (!mem_req) break;
                req_cnt++;
                @(negedge clk);
            end
            check("timeout req_cycles", 32'(req_cnt),  32'd4);
            check("timeout bus_err",    32'(bus_err),  32'h1);
            check("timeout wb_valid",   32'(wb_valid), 32'h0);
            check("timeout stall",      32'(stall),    32'h0);
            @(negedge clk);
            check("timeout bus_err_pulse", 32'(bus_err),  32'h0);
            check("timeout late_wb",       32'(wb_valid), 32'h0);
        end

        // Reset mid-access, then a late ack
        @(negedge clk);
        drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0E00, 32'h0, 5'd15);
        @(negedge clk);
        in_valid = 1'b0;
        check("midrst req_before", 32'(mem_req), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("midrst req_async", 32'(mem_req), 32'h0);
        check("midrst stall",     32'(stall),   32'h0);
        mem_rdata = 32'h7777_7777;
        mem_ack   = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check_reset_outputs($sformatf("midrst%0d", c));
        end
        mem_ack = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
